imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory; the core is its reader.
- Receives a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes each word through the instruction memory write port.
- Holds the core in reset until the whole program is written, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first program word.
- MAX_WORDS, 1024, largest program length accepted, in words.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_valid  input  1  byte available on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_wr_en  output  1  instruction memory write strobe.
- mem_byt_en  output  4  byte enables: 4'b1111 while writing, else 4'b0000.
- mem_adrs_wr  output  32  write byte address.
- mem_wr_data  output  32  write word.
- core_rst  output  1  active-high reset to the core.
- busy  output  1  high in LEN, DATA or WRITE.
- done  output  1  load completed successfully.
- err  output  1  length rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; core_rst=1.
  - rx_ready, mem_wr_en, busy, done, err = 0.
  - mem_byt_en=0, mem_adrs_wr=0, mem_wr_data=0.
  - All counters and the assembly register are cleared.
- Byte acceptance: a byte is taken only when rx_valid && rx_ready. rx_ready=1 only in LEN and DATA, and is registered from the state.
- Byte assembly: a 2-bit byte counter places accepted byte k at bits [8k+7:8k]. The counter wraps 3->0 on the 4th byte.
- Stream format: a 32-bit word count N, little-endian, followed by N words, each little-endian.
- IDLE:
  - core_rst=1.
  - start -> LEN; clears the word index and byte counter.
- LEN: on the 4th accepted byte, the completed value is N.
  - N==0 -> DONE.
  - N>MAX_WORDS -> ERR.
  - otherwise -> DATA.
- DATA: on the 4th accepted byte -> WRITE.
- WRITE: lasts exactly one cycle.
  - mem_wr_en=1, mem_byt_en=4'b1111.
  - mem_adrs_wr = BASE_ADDR + 4*word_idx, computed modulo 2^32.
  - mem_wr_data = assembled word.
  - rx_ready=0.
  - Next cycle: word_idx increments. If the new word_idx==N -> DONE, else -> DATA.
- Write outputs are driven combinationally from registered state and registers, valid in the WRITE cycle only. mem_wr_en is never high outside WRITE.
- DONE:
  - core_rst=0, done=1; remains until start.
  - start -> LEN with core_rst=1 and done=0 in the same cycle the state changes. The core is re-held during a reload.
- ERR:
  - core_rst=1, err=1; remains until start.
  - start -> LEN and clears err.
- start while in LEN, DATA or WRITE is ignored.
- Gaps in rx_valid: any number of idle cycles between bytes is legal. State and partial word are held.
- Reset during a load: returns to IDLE and reasserts core_rst. A partially written program is abandoned and no further writes occur.
- core_rst is registered (glitch-free). It deasserts in the first DONE cycle and is asserted in every other state.
- Throughput: a word completes in at most 5 cycles (4 byte cycles plus 1 WRITE cycle) when rx_valid is held high.

Test Plan:
- Nominal 2-word load. Stimulus: start, then bytes 02 00 00 00, 13 05 10 00, 93 05 20 00, with rx_valid held high. Response: writes of 0x00100513 @0x0 and 0x00200593 @0x4, each with mem_byt_en=1111. Then done=1 and core_rst=0, with no third write.
- Backpressure and gaps. Stimulus: the same stream with rx_valid toggled 1-0-0-1. Response: identical writes and addresses. rx_ready=0 during WRITE cycles; no byte is lost or duplicated.
- Zero length. Stimulus: start, then bytes 00 00 00 00. Response: DONE directly, no mem_wr_en pulse, core_rst falls.
- Overflow. Stimulus: with MAX_WORDS=4, send length 05 00 00 00. Response: err=1, core_rst stays 1, no writes. A following start clears err and re-enters LEN.
- Reset mid-load. Stimulus: pull rst low after the 2nd data byte of word 1. Response: immediate IDLE, core_rst=1, outputs zero. A fresh start with a full stream loads correctly from BASE_ADDR.
- Reload after DONE. Stimulus: start while in DONE. Response: core_rst rises, done falls, and new words overwrite from BASE_ADDR.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that fills instruction memory and holds the core in reset until done
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_wr_en,
  output logic [3:0]  mem_byt_en,
  output logic [31:0] mem_adrs_wr,
  output logic [31:0] mem_wr_data,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;
  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);
  state_t      state, state_nx;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_q, len_q, word_idx;
  logic        core_rst_q;
  logic        accept, last_byte, start_ok, wr;
  logic [31:0] full_word;
  assign accept    = rx_valid && rx_ready;
  assign last_byte = accept && byte_cnt == 2'd3;
  assign full_word = {rx_data, asm_q[23:0]};
  assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
  assign wr        = state == WRITE;
  // next-state selection; the completed length word is taken straight from the incoming byte
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LEN : IDLE;
      LEN:     state_nx = !last_byte ? LEN : full_word == 32'd0 ? DONE : full_word > MAX_N ? ERR : DATA;
      DATA:    state_nx = last_byte ? WRITE : DATA;
      WRITE:   state_nx = (word_idx + 32'd1 == len_q) ? DONE : DATA;
      DONE:    state_nx = start ? LEN : DONE;
      ERR:     state_nx = start ? LEN : ERR;
      default: state_nx = IDLE;
    endcase
  end
  // state, byte assembly, word index and a glitch-free core reset derived from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      asm_q      <= 32'd0;
      len_q      <= 32'd0;
      word_idx   <= 32'd0;
      core_rst_q <= 1'b1;
    end else begin
      state      <= state_nx;
      core_rst_q <= state_nx != DONE;
      if (start_ok) begin
        byte_cnt <= 2'd0;
        asm_q    <= 32'd0;
        word_idx <= 32'd0;
      end else begin
        if (accept) begin
          asm_q[{byte_cnt, 3'b000} +: 8] <= rx_data;
          byte_cnt <= byte_cnt + 2'd1;
        end
        if (state == LEN && last_byte) len_q <= full_word;
        if (wr) word_idx <= word_idx + 32'd1;
      end
    end
  end
  assign rx_ready    = state == LEN || state == DATA;
  assign mem_wr_en   = wr;
  assign mem_byt_en  = {4{wr}};
  assign mem_adrs_wr = wr ? BASE_ADDR + {word_idx[29:0], 2'b00} : 32'd0;
  assign mem_wr_data = wr ? asm_q : 32'd0;
  assign core_rst    = core_rst_q;
  assign busy        = state == LEN || state == DATA || state == WRITE;
  assign done        = state == DONE;
  assign err         = state == ERR;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_wr_en, core_rst, busy, done, err;
  logic [3:0]  mem_byt_en;
  logic [31:0] mem_adrs_wr, mem_wr_data;
  int          tests = 0;
  int          fails = 0;
  int          wr_n = 0;
  int          bad = 0;
  int          base;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_wr_en(mem_wr_en), .mem_byt_en(mem_byt_en),
    .mem_adrs_wr(mem_adrs_wr), .mem_wr_data(mem_wr_data), .core_rst(core_rst),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = mem_adrs_wr;
        wr_data[wr_n] = mem_wr_data;
      end
      wr_n = wr_n + 1;
      if (rx_ready || mem_byt_en != 4'hF) bad = bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept_timeout", 32'(n < 30), 32'd1);
    @(negedge clk);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic pulse_start();
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    rx_valid = 1'b0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", 32'(n < 40), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_flags", {28'd0, rx_ready, busy, done, err}, 32'd0);
    check("rst_wr", {27'd0, mem_wr_en, mem_byt_en}, 32'd0);
    check("rst_addr_data", mem_adrs_wr | mem_wr_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_core_rst", 32'(core_rst), 32'd1);

    base = wr_n;
    pulse_start();
    check("len_flags", {29'd0, rx_ready, busy, core_rst}, 32'd7);
    send_word(32'd2, 0);
    send_word(32'h0010_0513, 0);
    send_word(32'h0020_0593, 0);
    wait_end();
    repeat (3) @(negedge clk);
    check("nom_count", 32'(wr_n - base), 32'd2);
    check("nom_addr0", wr_addr[base], 32'h0);
    check("nom_data0", wr_data[base], 32'h0010_0513);
    check("nom_addr1", wr_addr[base+1], 32'h4);
    check("nom_data1", wr_data[base+1], 32'h0020_0593);
    check("nom_done", {30'd0, done, core_rst}, 32'd2);

    base = wr_n;
    pulse_start();
    check("reload_core_rst_done", {30'd0, core_rst, done}, 32'd2);
    send_word(32'd2, 2);
    send_word(32'hDEAD_BEEF, 2);
    send_word(32'h1234_5678, 2);
    wait_end();
    check("gap_count", 32'(wr_n - base), 32'd2);
    check("gap_addr0", wr_addr[base], 32'h0);
    check("gap_data0", wr_data[base], 32'hDEAD_BEEF);
    check("gap_addr1", wr_addr[base+1], 32'h4);
    check("gap_data1", wr_data[base+1], 32'h1234_5678);
    check("gap_done", {30'd0, done, core_rst}, 32'd2);

    base = wr_n;
    pulse_start();
    send_word(32'd0, 0);
    wait_end();
    @(negedge clk);
    check("zero_count", 32'(wr_n - base), 32'd0);
    check("zero_done", {29'd0, done, core_rst, err}, 32'd4);

    base = wr_n;
    pulse_start();
    send_word(32'd5, 0);
    wait_end();
    repeat (2) @(negedge clk);
    check("ovf_err", {29'd0, err, core_rst, done}, 32'd6);
    check("ovf_count", 32'(wr_n - base), 32'd0);
    pulse_start();
    check("ovf_clear", {29'd0, err, busy, rx_ready}, 32'd3);
    send_word(32'd4, 0);
    send_word(32'hA3A2_A1A0, 0);
    send_word(32'hB3B2_B1B0, 0);
    send_word(32'hC3C2_C1C0, 0);
    send_word(32'hD3D2_D1D0, 0);
    wait_end();
    check("max_count", 32'(wr_n - base), 32'd4);
    check("max_addr3", wr_addr[base+3], 32'hC);
    check("max_data3", wr_data[base+3], 32'hD3D2_D1D0);
    check("max_data0", wr_data[base], 32'hA3A2_A1A0);
    check("max_done", {30'd0, done, core_rst}, 32'd2);

    base = wr_n;
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_core_rst", 32'(core_rst), 32'd1);
    check("mid_rst_flags", {28'd0, rx_ready, busy, done, err}, 32'd0);
    check("mid_rst_wr", {27'd0, mem_wr_en, mem_byt_en}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_idle", {30'd0, busy, core_rst}, 32'd1);
    check("mid_rst_count", 32'(wr_n - base), 32'd0);
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    wait_end();
    check("after_rst_count", 32'(wr_n - base), 32'd1);
    check("after_rst_addr", wr_addr[base], 32'h0);
    check("after_rst_data", wr_data[base], 32'hCAFE_F00D);
    check("after_rst_done", {30'd0, done, core_rst}, 32'd2);
    check("write_cycle_ready_be", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
